// File: rtl/vc_shared_fifo_pkg.sv
// vc_shared_fifo_pkg: sizing helper and flit field layout shared by the VC input buffer
package vc_shared_fifo_pkg;

    // ceil(log2(v)), at least 1 so one-hot index and pointer fields never collapse to zero width
    function automatic int log2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++)
            if ((1 << r) < v) r = i + 1;
        return r;
    endfunction

    // flit layout, LSB first: payload, then VC one-hot, then type at the MSBs
    function automatic int pyld_lsb();
        return 0;
    endfunction

    function automatic int vc_lsb(input int pyld_w);
        return pyld_w;
    endfunction

    function automatic int type_lsb(input int pyld_w, input int vc_n);
        return pyld_w + vc_n;
    endfunction

endpackage

// File: rtl/vc_fifo_ram.sv
// vc_fifo_ram: simple dual-port RAM with registered read data and async-reset output register
module vc_fifo_ram #(
    parameter int DW = 34,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [2**AW];

    // storage array, deliberately not reset
    always_ff @(posedge clk)
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;

    // read register samples the pre-write contents on a same-address collision and holds otherwise
    always_ff @(posedge clk or negedge reset)
        if (!reset) rd_data_o <= '0;
        else if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];

endmodule

// File: rtl/vc_shared_fifo.sv
// vc_shared_fifo: per-port input buffer, one shared RAM split into equal circular queues per VC
module vc_shared_fifo
    import vc_shared_fifo_pkg::*;
#(
    parameter int VC_NUM_PER_PORT      = 4,
    parameter int PORT_NUM             = 5,
    parameter int PYLD_WIDTH           = 32,
    parameter int BUFFER_NUM_PER_VC    = 4,
    parameter int FLIT_TYPE_WIDTH      = 2,
    parameter int ENABLE_MIN_DEPTH_OUT = 0,
    parameter int FLIT_WIDTH           = PYLD_WIDTH + FLIT_TYPE_WIDTH + VC_NUM_PER_PORT,
    parameter int VC_FULL_WIDTH        = (ENABLE_MIN_DEPTH_OUT == 1) ? 2 * VC_NUM_PER_PORT : VC_NUM_PER_PORT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [FLIT_WIDTH-1:0]      din,
    input  logic [VC_NUM_PER_PORT-1:0] vc_num_wr,
    input  logic [VC_NUM_PER_PORT-1:0] vc_num_rd,
    input  logic                       wr_en,
    input  logic                       rd_en,
    output logic [FLIT_WIDTH-1:0]      dout,
    output logic [VC_FULL_WIDTH-1:0]   vc_nearly_full,
    output logic [VC_NUM_PER_PORT-1:0] vc_not_empty
);

    localparam int VC       = VC_NUM_PER_PORT;
    localparam int PTR_W    = log2(BUFFER_NUM_PER_VC);
    localparam int SEL_W    = log2(VC_NUM_PER_PORT);
    localparam int DEPTH_W  = PTR_W + 1;
    localparam int ADDR_W   = SEL_W + PTR_W;
    localparam int RAM_W    = FLIT_TYPE_WIDTH + PYLD_WIDTH;
    localparam int TYPE_LSB = type_lsb(PYLD_WIDTH, VC);
    localparam int VC_LSB   = vc_lsb(PYLD_WIDTH);
    localparam int PY_LSB   = pyld_lsb();

    logic [VC-1:0][PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [VC-1:0][DEPTH_W-1:0] depth_q, depth_d;
    logic [VC-1:0]              wr_ok, rd_ok, nearly_full;
    logic [RAM_W-1:0]           ram_din, ram_dout;
    logic [ADDR_W-1:0]          wr_addr, rd_addr;
    logic                       unused_vc_field;

    // index of a one-hot select; extra set bits OR their indices together
    function automatic logic [SEL_W-1:0] onehot_to_bin(input logic [VC-1:0] oh);
        onehot_to_bin = '0;
        for (int i = 0; i < VC; i++)
            if (oh[i]) onehot_to_bin |= SEL_W'(i);
    endfunction

    // pointer picked by a one-hot select; extra set bits OR their pointers together
    function automatic logic [PTR_W-1:0] ptr_mux(input logic [VC-1:0] oh, input logic [VC-1:0][PTR_W-1:0] p);
        ptr_mux = '0;
        for (int i = 0; i < VC; i++)
            if (oh[i]) ptr_mux |= p[i];
    endfunction

    assign ram_din         = {din[TYPE_LSB +: FLIT_TYPE_WIDTH], din[PY_LSB +: PYLD_WIDTH]};
    assign unused_vc_field = ^din[VC_LSB +: VC];
    assign wr_addr         = {onehot_to_bin(vc_num_wr), ptr_mux(vc_num_wr, wr_ptr_q)};
    assign rd_addr         = {onehot_to_bin(vc_num_rd), ptr_mux(vc_num_rd, rd_ptr_q)};
    assign dout            = {ram_dout[PYLD_WIDTH +: FLIT_TYPE_WIDTH], {VC{1'b0}}, ram_dout[PY_LSB +: PYLD_WIDTH]};

    // per-VC accept decisions; a full VC still accepts a write when the same VC is read that cycle
    always_comb begin
        rd_ok    = '0;
        wr_ok    = '0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        depth_d  = depth_q;
        for (int i = 0; i < VC; i++) begin
            rd_ok[i]    = rd_en && vc_num_rd[i] && (depth_q[i] != '0);
            wr_ok[i]    = wr_en && vc_num_wr[i] && ((depth_q[i] != DEPTH_W'(BUFFER_NUM_PER_VC)) || rd_ok[i]);
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(wr_ok[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(rd_ok[i]);
            depth_d[i]  = depth_q[i] + DEPTH_W'(wr_ok[i]) - DEPTH_W'(rd_ok[i]);
        end
    end

    // pointer and depth registers
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            depth_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            depth_q  <= depth_d;
        end

    // status flags straight from registered depth
    always_comb begin
        nearly_full  = '0;
        vc_not_empty = '0;
        for (int i = 0; i < VC; i++) begin
            nearly_full[i]  = depth_q[i] >= DEPTH_W'(BUFFER_NUM_PER_VC - 1);
            vc_not_empty[i] = depth_q[i] != '0;
        end
    end

    generate
        if (ENABLE_MIN_DEPTH_OUT == 1) begin : g_min
            logic [VC-1:0]      min_oh;
            logic [DEPTH_W-1:0] min_val;
            // shallowest VC as one-hot; strict compare keeps ties on the lowest index
            always_comb begin
                min_oh  = VC'(1);
                min_val = depth_q[0];
                for (int i = 1; i < VC; i++)
                    if (depth_q[i] < min_val) begin
                        min_val = depth_q[i];
                        min_oh  = VC'(1) << i;
                    end
            end
            assign vc_nearly_full = {min_oh, nearly_full};
        end else begin : g_nomin
            assign vc_nearly_full = nearly_full;
        end
    endgenerate

    // report strobes whose select names no VC; such strobes change no state
    always_ff @(posedge clk)
        if (reset) begin
            assert (!(wr_en && vc_num_wr == '0)) else $warning("vc_shared_fifo: wr_en with empty VC select");
            assert (!(rd_en && vc_num_rd == '0)) else $warning("vc_shared_fifo: rd_en with empty VC select");
        end

    vc_fifo_ram #(
        .DW(RAM_W),
        .AW(ADDR_W)
    ) u_ram (
        .clk      (clk),
        .reset    (reset),
        .wr_en_i  (|wr_ok),
        .wr_addr_i(wr_addr),
        .wr_data_i(ram_din),
        .rd_en_i  (|rd_ok),
        .rd_addr_i(rd_addr),
        .rd_data_o(ram_dout)
    );

endmodule

// File: tb/tb_vc_shared_fifo.sv
// tb_vc_shared_fifo: directed stimulus with a queue scoreboard checking dout and status flags
module tb_vc_shared_fifo;

    logic        clk, reset;
    logic [37:0] din, dout;
    logic [3:0]  vc_num_wr, vc_num_rd, vc_not_empty;
    logic        wr_en, rd_en;
    logic [7:0]  vc_nearly_full;

    logic [37:0] exp_q [$];
    logic [37:0] hold;
    logic        exp_rd, cap;
    int          n_cmp, n_bad;

    vc_shared_fifo #(
        .VC_NUM_PER_PORT(4),
        .PORT_NUM(5),
        .PYLD_WIDTH(32),
        .BUFFER_NUM_PER_VC(4),
        .FLIT_TYPE_WIDTH(2),
        .ENABLE_MIN_DEPTH_OUT(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .din(din),
        .vc_num_wr(vc_num_wr),
        .vc_num_rd(vc_num_rd),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .dout(dout),
        .vc_nearly_full(vc_nearly_full),
        .vc_not_empty(vc_not_empty)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic logic [37:0] f(input logic [1:0] t, input logic [31:0] p);
        return {t, 4'b0000, p};
    endfunction

    task automatic chk(input string name, input logic [37:0] got, input logic [37:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // one cycle: optional write, optional read; v says whether the read must return e
    task automatic go(input logic w, input logic [3:0] wv, input logic [1:0] t, input logic [31:0] p,
                      input logic r, input logic [3:0] rv, input logic v, input logic [37:0] e);
        wr_en     = w;
        vc_num_wr = wv;
        din       = {t, wv, p};
        rd_en     = r;
        vc_num_rd = rv;
        exp_rd    = v;
        if (v) exp_q.push_back(e);
        @(negedge clk);
        wr_en  = 0;
        rd_en  = 0;
        exp_rd = 0;
    endtask

    task automatic wr(input logic [3:0] wv, input logic [1:0] t, input logic [31:0] p);
        go(1, wv, t, p, 0, 4'b0, 0, '0);
    endtask

    task automatic rd(input logic [3:0] rv, input logic v, input logic [37:0] e);
        go(0, 4'b0, 2'b0, 32'h0, 1, rv, v, e);
    endtask

    always @(posedge clk) cap = exp_rd;

    // monitor: a registered read shows on dout after the edge; otherwise dout must hold
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            hold = '0;
        end else if (cap) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_underflow: read observed with no expected entry");
            end else hold = exp_q.pop_front();
        end
        n_cmp++;
        if (dout !== hold) begin
            n_bad++;
            $display("FAIL dout: got %h expected %h", dout, hold);
        end
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        hold = '0; cap = 0; exp_rd = 0;
        wr_en = 0; rd_en = 0; din = '0; vc_num_wr = '0; vc_num_rd = '0;
        reset = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("rst_not_empty", 38'(vc_not_empty), 38'h0);
        chk("rst_nearly_full", 38'(vc_nearly_full[3:0]), 38'h0);
        chk("rst_min_depth", 38'(vc_nearly_full[7:4]), 38'h1);
        chk("rst_dout", dout, 38'h0);

        wr(4'b0001, 2'b01, 32'h11);
        wr(4'b0001, 2'b01, 32'h22);
        wr(4'b0001, 2'b01, 32'h33);
        chk("vc0_not_empty", 38'(vc_not_empty), 38'h1);
        chk("vc0_nf_depth3", 38'(vc_nearly_full[3:0]), 38'h1);
        rd(4'b0001, 1, f(2'b01, 32'h11));
        rd(4'b0001, 1, f(2'b01, 32'h22));
        chk("vc0_ne_after_2rd", 38'(vc_not_empty), 38'h1);
        rd(4'b0001, 1, f(2'b01, 32'h33));
        chk("vc0_ne_after_3rd", 38'(vc_not_empty), 38'h0);

        wr(4'b0100, 2'b10, 32'hA0);
        wr(4'b0100, 2'b10, 32'hA1);
        chk("vc2_nf_depth2", 38'(vc_nearly_full[3:0]), 38'h0);
        wr(4'b0100, 2'b10, 32'hA2);
        chk("vc2_nf_depth3", 38'(vc_nearly_full[3:0]), 38'h4);
        wr(4'b0100, 2'b10, 32'hA3);
        chk("vc2_min_depth", 38'(vc_nearly_full[7:4]), 38'h1);
        wr(4'b0100, 2'b10, 32'hA4);
        chk("vc2_full_drop_nf", 38'(vc_nearly_full[3:0]), 38'h4);
        rd(4'b0100, 1, f(2'b10, 32'hA0));
        rd(4'b0100, 1, f(2'b10, 32'hA1));
        rd(4'b0100, 1, f(2'b10, 32'hA2));
        rd(4'b0100, 1, f(2'b10, 32'hA3));
        rd(4'b0100, 0, '0);
        chk("vc2_ne_after_drain", 38'(vc_not_empty), 38'h0);

        wr(4'b0001, 2'b11, 32'hAA);
        wr(4'b1000, 2'b11, 32'hBB);
        wr(4'b0001, 2'b11, 32'hCC);
        chk("ilv_not_empty", 38'(vc_not_empty), 38'h9);
        chk("ilv_min_depth", 38'(vc_nearly_full[7:4]), 38'h2);
        rd(4'b1000, 1, f(2'b11, 32'hBB));
        rd(4'b0001, 1, f(2'b11, 32'hAA));
        rd(4'b0001, 1, f(2'b11, 32'hCC));
        chk("ilv_ne_after", 38'(vc_not_empty), 38'h0);

        wr(4'b1000, 2'b01, 32'hD0);
        wr(4'b1000, 2'b01, 32'hD1);
        wr(4'b1000, 2'b01, 32'hD2);
        wr(4'b1000, 2'b01, 32'hD3);
        go(1, 4'b1000, 2'b01, 32'hD4, 1, 4'b1000, 1, f(2'b01, 32'hD0));
        chk("full_wr_rd_nf", 38'(vc_nearly_full[3:0]), 38'h8);
        wr(4'b1000, 2'b01, 32'hD5);
        rd(4'b1000, 1, f(2'b01, 32'hD1));
        rd(4'b1000, 1, f(2'b01, 32'hD2));
        chk("vc3_nf_depth2", 38'(vc_nearly_full[3:0]), 38'h0);
        rd(4'b1000, 1, f(2'b01, 32'hD3));
        rd(4'b1000, 1, f(2'b01, 32'hD4));
        chk("vc3_ne_after", 38'(vc_not_empty), 38'h0);

        wr(4'b0010, 2'b10, 32'h51);
        wr(4'b0010, 2'b10, 32'h52);
        go(1, 4'b0010, 2'b10, 32'h53, 1, 4'b0010, 1, f(2'b10, 32'h51));
        chk("same_vc_nf", 38'(vc_nearly_full[3:0]), 38'h0);
        chk("same_vc_ne", 38'(vc_not_empty), 38'h2);
        rd(4'b0010, 1, f(2'b10, 32'h52));
        rd(4'b0010, 1, f(2'b10, 32'h53));
        go(1, 4'b0010, 2'b10, 32'h54, 1, 4'b0010, 0, '0);
        chk("empty_rd_wr_ne", 38'(vc_not_empty), 38'h2);
        rd(4'b0010, 1, f(2'b10, 32'h54));
        chk("vc1_ne_after", 38'(vc_not_empty), 38'h0);

        wr(4'b0001, 2'b00, 32'h61);
        wr(4'b0001, 2'b00, 32'h62);
        wr(4'b0001, 2'b00, 32'h63);
        wr(4'b0010, 2'b00, 32'h71);
        wr(4'b0100, 2'b00, 32'h81);
        wr(4'b1000, 2'b00, 32'h91);
        wr(4'b1000, 2'b00, 32'h92);
        chk("md_not_empty", 38'(vc_not_empty), 38'hF);
        chk("md_nearly_full", 38'(vc_nearly_full[3:0]), 38'h1);
        chk("md_3112", 38'(vc_nearly_full[7:4]), 38'h2);
        go(1, 4'b0010, 2'b00, 32'h72, 1, 4'b0001, 1, f(2'b00, 32'h61));
        chk("md_2212", 38'(vc_nearly_full[7:4]), 38'h4);
        chk("md_nf_after", 38'(vc_nearly_full[3:0]), 38'h0);

        wr_en = 1; vc_num_wr = 4'b0001; din = {2'b01, 4'b0001, 32'hEE};
        rd_en = 1; vc_num_rd = 4'b0010;
        #2 reset = 0;
        #1;
        chk("async_rst_ne", 38'(vc_not_empty), 38'h0);
        chk("async_rst_nf", 38'(vc_nearly_full[3:0]), 38'h0);
        chk("async_rst_min", 38'(vc_nearly_full[7:4]), 38'h1);
        chk("async_rst_dout", dout, 38'h0);
        @(negedge clk);
        wr_en = 0; rd_en = 0;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("post_rst_ne", 38'(vc_not_empty), 38'h0);
        wr(4'b0100, 2'b11, 32'hE1);
        chk("post_rst_wr_ne", 38'(vc_not_empty), 38'h4);
        rd(4'b0100, 1, f(2'b11, 32'hE1));
        repeat (2) @(negedge clk);
        chk("sb_drained", 38'(exp_q.size()), 38'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vc_shared_fifo.md
Name: vc_shared_fifo

Overview:
Input-port buffer for a VC-based mesh NoC router. All virtual channels (VCs) of one port share a single dual-port RAM, partitioned into equal per-VC circular queues. Per-VC read/write pointers and depth counters produce nearly-full and not-empty status for flow control and the VC allocator. VCs are selected with one-hot vectors. Optionally, a one-hot "minimum-depth VC" indicator is also output.

Parameters:
VC_NUM_PER_PORT 4: number of VCs; power of two, >=2.
PORT_NUM 5: router port count; informational only.
PYLD_WIDTH 32: flit payload width.
BUFFER_NUM_PER_VC 4: slots per VC; power of two, >=2.
FLIT_TYPE_WIDTH 2: flit type field width.
ENABLE_MIN_DEPTH_OUT 0: when 1, append the minimum-depth one-hot vector to vc_nearly_full.
FLIT_WIDTH derived: PYLD_WIDTH+FLIT_TYPE_WIDTH+VC_NUM_PER_PORT.
VC_FULL_WIDTH derived: 2*VC_NUM_PER_PORT if ENABLE_MIN_DEPTH_OUT=1, else VC_NUM_PER_PORT.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
din  in  FLIT_WIDTH  flit in; layout {type[FLIT_TYPE_WIDTH], vc[VC_NUM_PER_PORT], payload[PYLD_WIDTH]}.
vc_num_wr  in  VC_NUM_PER_PORT  one-hot write VC.
vc_num_rd  in  VC_NUM_PER_PORT  one-hot read VC.
wr_en  in  1  write strobe.
rd_en  in  1  read strobe.
dout  out  FLIT_WIDTH  read flit, same layout as din.
vc_nearly_full  out  VC_FULL_WIDTH  [VC-1:0] nearly-full flags; upper half is the min-depth one-hot (present only when enabled).
vc_not_empty  out  VC_NUM_PER_PORT  per-VC not-empty flags.

Behaviour:
- Constants: PTR_W=log2(BUFFER_NUM_PER_VC); SEL_W=log2(VC_NUM_PER_PORT); RAM depth=VC_NUM_PER_PORT*BUFFER_NUM_PER_VC.
- Address is {binary(vc one-hot), ptr[vc]}. The binary index comes from the one-hot-to-binary encoder; ptr comes from the one-hot mux of the pointer array.
- RAM width is FLIT_TYPE_WIDTH+PYLD_WIDTH. The VC field of din is not stored.
- Write (wr_en=1, VC i selected, VC i not full or also being read):
  - RAM[{i, wr_ptr[i]}] <= type+payload.
  - wr_ptr[i] increments and wraps mod BUFFER_NUM_PER_VC.
- Read (rd_en=1, VC j selected, depth[j]>0):
  - dout is registered; it updates at the edge after the rd_en cycle (1-cycle latency).
  - rd_ptr[j] increments and wraps.
- dout holds its value when no valid read occurs.
- dout VC field is driven with all zeros, never X.
- Depth per VC:
  - write-only: depth+1; read-only: depth-1; write and read on the same VC in the same cycle: unchanged.
  - Depth width is PTR_W+1, range 0..BUFFER_NUM_PER_VC.
- Flags: vc_nearly_full[i] = depth[i] >= BUFFER_NUM_PER_VC-1. vc_not_empty[i] = depth[i] > 0. Both are combinational from registered depth.
- Boundary conditions:
  - Write to a full VC with no same-VC read: dropped; RAM, pointer and depth unchanged.
  - Read of an empty VC: ignored; pointer, depth and dout unchanged. A simultaneous write to that VC still succeeds (depth 0->1).
  - Read and write on different VCs in one cycle are independent.
  - Read and write to the same address in one cycle: read returns the old RAM contents.
- Zero or non-one-hot select: the mux ORs the selected entries, and the encoder ORs the indices of the set bits. wr_en/rd_en with an all-zero select performs no pointer or depth update (no VC is enabled). A simulation-only message reports the condition.
- Min-depth out: one-hot marking the VC with the smallest depth; ties go to the lowest index.
- Reset (asynchronous assert, any time including mid-transfer):
  - all pointers and depths go to 0; dout goes to 0.
  - vc_not_empty=0 and vc_nearly_full[VC-1:0]=0.
  - min-depth vector=...0001.
  - RAM contents are not reset.

Decomposition:
- Shared package: log2 function; flit field width and location constants (type MSBs, VC field, payload LSBs).
- Sub-modules: vc_fifo_ram (simple dual-port RAM with registered read and async-reset output register).
- The one-hot mux, one-hot-to-binary encoder and min-depth finder are small generate/function blocks inside the top module.

Test Plan:
- Reset, then idle: vc_not_empty=0000, vc_nearly_full=0000, dout=0.
- Write payloads 0x11, 0x22, 0x33 with type 2'b01 to VC 0001, then read 3 times: dout = {01, 0000, 0x11/0x22/0x33}, each one cycle after its rd_en; vc_not_empty[0] falls after the third read.
- Fill VC 0100 with 4 flits: nearly_full[2] rises after the 3rd write; a 5th write is dropped and the read-back sequence is unchanged.
- Interleave VCs: write A to VC0, B to VC3, C to VC0, then read VC3, then VC0 twice: dout = B, A, C, confirming per-VC isolation and wrap-around after 6 write/read cycles of one VC.
- Simultaneous write and read on the same non-empty VC: depth constant and FIFO order preserved. Read on an empty VC with a concurrent write: depth becomes 1 and dout is unchanged.
- ENABLE_MIN_DEPTH_OUT=1, depths {3,1,1,2}: upper half = 0010. Assert reset mid-stream: all flags clear asynchronously.
